// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset / fPLL bring-up sequencer.
//   state_t     : FSM state encoding, also exported on state_o for debug
//   RETRY_W     : width of the saturating retry counter
//   clog2_min1  : counter width helper that never returns 0
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        WAIT_CAL  = 3'd1,
        WAIT_LOCK = 3'd2,
        FILTER    = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } state_t;

    localparam int RETRY_W = 8;

    // A counter that only needs to hold 0 still needs one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk      : destination clock
//   rst      : synchronous active-high reset, both flops clear to 0
//   i_async  : asynchronous input level
//   o_sync   : synchronised level, two clk cycles behind i_async
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Reset and fPLL bring-up sequencer.
// Holds the fPLL in power-down, waits for calibration to finish and for a
// filtered lock, then releases N_RST reset domains one at a time (bit 0
// first). Lock loss after release, or a timeout while waiting, restarts the
// whole sequence from power-down. Only timeouts are counted as retries.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   pll_locked    : fPLL lock, asynchronous
//   pll_cal_busy  : fPLL calibration busy, asynchronous
//   pll_powerdown : fPLL power-down request
//   rst_out       : per-domain active-high resets, bit 0 released first
//   ready         : all domains released and lock holding
//   retry_cnt     : saturating count of timeout restarts
//   state_o       : current FSM state (debug)
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_RST     = 4,
    parameter int PD_CYC    = 1000,
    parameter int LOCK_FILT = 64,
    parameter int STAGE_CYC = 256,
    parameter int LOCK_TO   = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               pll_cal_busy,
    output logic               pll_powerdown,
    output logic [N_RST-1:0]   rst_out,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    // One phase counter serves PWRDN, FILTER and RELEASE; it is sized for
    // the longest of the three.
    localparam int CNT_W = clog2_min1(max3(PD_CYC, LOCK_FILT, STAGE_CYC));
    localparam int TO_W  = clog2_min1(LOCK_TO);
    localparam int K_W   = clog2_min1(N_RST);

    localparam logic [CNT_W-1:0] PD_LAST    = CNT_W'(PD_CYC - 1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(LOCK_TO - 1);
    localparam logic [K_W-1:0]   K_LAST     = K_W'(N_RST - 1);

    logic w_lock_s;
    logic w_cal_s;

    sync_2ff u_sync_lock (
        .clk     (clk),
        .rst     (rst),
        .i_async (pll_locked),
        .o_sync  (w_lock_s)
    );

    sync_2ff u_sync_cal (
        .clk     (clk),
        .rst     (rst),
        .i_async (pll_cal_busy),
        .o_sync  (w_cal_s)
    );

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic [K_W-1:0]       r_k;
    logic                 r_pd;
    logic [N_RST-1:0]     r_rst_out;
    logic                 r_ready;
    logic [RETRY_W-1:0]   r_retry;

    state_t w_state_nxt;
    logic   w_timeout;
    logic   w_stage_done;
    logic   w_to_hit;
    logic   w_to_run;

    // Next-state decision. Timeout outranks lock loss, which outranks
    // normal progress.
    always_comb begin
        w_state_nxt  = r_state;
        w_timeout    = 1'b0;
        w_stage_done = 1'b0;
        w_to_hit     = (r_to_cnt == TO_LAST);

        case (r_state)
            PWRDN: begin
                if (r_cnt == PD_LAST) w_state_nxt = WAIT_CAL;
            end
            WAIT_CAL: begin
                if (w_to_hit) begin
                    w_state_nxt = PWRDN;
                    w_timeout   = 1'b1;
                end else if (!w_cal_s) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (w_to_hit) begin
                    w_state_nxt = PWRDN;
                    w_timeout   = 1'b1;
                end else if (w_lock_s) begin
                    w_state_nxt = FILTER;
                end
            end
            FILTER: begin
                // A lock dropout here only restarts filtering; the timeout
                // keeps running so a chattering lock still ends in a retry.
                if (w_to_hit) begin
                    w_state_nxt = PWRDN;
                    w_timeout   = 1'b1;
                end else if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_cnt == FILT_LAST) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_lock_s) begin
                    w_state_nxt = PWRDN;
                end else if (r_cnt == STAGE_LAST) begin
                    w_stage_done = 1'b1;
                    if (r_k == K_LAST) w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_lock_s) w_state_nxt = PWRDN;
            end
            default: begin
                w_state_nxt = PWRDN;
            end
        endcase

        // The timeout window spans WAIT_CAL..FILTER; entering it from
        // PWRDN always starts from zero.
        w_to_run = (r_state inside {WAIT_CAL, WAIT_LOCK, FILTER}) &&
                   (w_state_nxt inside {WAIT_CAL, WAIT_LOCK, FILTER});
    end

    // State, counters and registered outputs. Outputs are derived from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PWRDN;
            r_cnt     <= '0;
            r_to_cnt  <= '0;
            r_k       <= '0;
            r_pd      <= 1'b1;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_retry   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Only the timed states count, so RUN and the wait states never
            // run the phase counter up to a wrap.
            if ((w_state_nxt != r_state) || w_stage_done) begin
                r_cnt <= '0;
            end else if (r_state inside {PWRDN, FILTER, RELEASE}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_to_cnt <= w_to_run ? (r_to_cnt + TO_W'(1)) : '0;

            if (w_state_nxt != RELEASE) begin
                r_k <= '0;
            end else if (w_stage_done) begin
                r_k <= r_k + K_W'(1);
            end

            r_pd    <= (w_state_nxt == PWRDN);
            r_ready <= (w_state_nxt == RUN);

            if (w_state_nxt == PWRDN) begin
                r_rst_out <= '1;
            end else if (w_stage_done) begin
                for (int i = 0; i < N_RST; i++) begin
                    if (r_k == K_W'(i)) r_rst_out[i] <= 1'b0;
                end
            end

            if (w_timeout && (r_retry != '1)) begin
                r_retry <= r_retry + RETRY_W'(1);
            end
        end
    end

    assign pll_powerdown = r_pd;
    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign retry_cnt     = r_retry;
    assign state_o       = r_state;

endmodule
